// File: rtl/wasm_core.sv
// wasm_core: minimal WebAssembly stack-machine core (nop/block/end/drop/i32.const/i32.add/i32.sub).
// Define WASM_CORE_I64_EN to add i64.const (0x42) and i64.add (0x7C).
module wasm_core #(
  parameter int MEM_DEPTH   = 3,
  parameter int STACK_DEPTH = 16,
  parameter int BLOCK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [63:0]          result,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error
);
  localparam int PCW = MEM_DEPTH + 1;
  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int DW  = $clog2(BLOCK_DEPTH + 1);
`ifdef WASM_CORE_I64_EN
  localparam int LEB_MAX  = 10;
  localparam int RAW_USED = 64;
`else
  localparam int LEB_MAX  = 5;
  localparam int RAW_USED = 32;
`endif
  localparam int RAW_W = 7 * LEB_MAX;

  localparam logic [3:0] TRAP_NONE    = 4'd0;
  localparam logic [3:0] TRAP_END     = 4'd1;
  localparam logic [3:0] TRAP_UNREACH = 4'd2;
  localparam logic [3:0] TRAP_ILLEGAL = 4'd3;
  localparam logic [3:0] TRAP_OVER    = 4'd4;
  localparam logic [3:0] TRAP_UNDER   = 4'd5;
  localparam logic [3:0] TRAP_MEM     = 4'd6;
  localparam logic [3:0] TRAP_BLOCK   = 4'd7;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [SPW:0]     sp_q, sp_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [3:0]       trap_q, trap_d;
  logic [63:0]      result_q, result_d;
  logic             empty_q, empty_d;
  logic [63:0]      stack_q [STACK_DEPTH];

  logic             wr_en;
  logic [SPW-1:0]   wr_idx;
  logic [63:0]      wr_data;
  logic [7:0]       opcode, blocktype;
  logic             blocktype_ok;
  logic [SPW-1:0]   top_idx, nxt_idx;
  logic [63:0]      top_val, nxt_val;
  logic [RAW_W-1:0] leb_raw;
  logic [3:0]       leb_len;
  logic             leb_done, leb_sign, leb_take;
  logic             is_const, is_bin;
  logic [63:0]      const_val, bin_val;
  logic             unused_bits;

  assign opcode       = mem_data[7:0];
  assign blocktype    = mem_data[15:8];
  assign blocktype_ok = (blocktype == 8'h40) || (blocktype == 8'h7F) || (blocktype == 8'h7E);
  assign top_idx      = sp_q[SPW-1:0] - SPW'(1);
  assign nxt_idx      = sp_q[SPW-1:0] - SPW'(2);
  assign top_val      = stack_q[top_idx];
  assign nxt_val      = stack_q[nxt_idx];

  // Signed LEB128 decode of the immediate starting at byte 1; raw value is sign-extended past the last group.
  always_comb begin
    leb_raw  = '0;
    leb_len  = 4'd0;
    leb_done = 1'b0;
    leb_sign = 1'b0;
    leb_take = 1'b0;
    for (int i = 0; i < LEB_MAX; i++) begin
      leb_take           = !leb_done;
      leb_raw[7*i +: 7]  = leb_take ? mem_data[8*(i+1) +: 7] : 7'd0;
      leb_sign           = leb_take ? mem_data[8*(i+1) + 6] : leb_sign;
      leb_len            = (leb_take && !mem_data[8*(i+1) + 7]) ? 4'(i + 1) : leb_len;
      leb_done           = leb_done | (leb_take & ~mem_data[8*(i+1) + 7]);
    end
    for (int j = 0; j < RAW_W; j++) begin
      leb_raw[j] = (leb_sign && (j >= 7 * int'(leb_len))) ? 1'b1 : leb_raw[j];
    end
  end

`ifdef WASM_CORE_I64_EN
  assign is_const  = (opcode == 8'h41) || (opcode == 8'h42);
  assign const_val = (opcode == 8'h42) ? leb_raw[63:0] : {32'd0, leb_raw[31:0]};
  assign is_bin    = (opcode == 8'h6A) || (opcode == 8'h6B) || (opcode == 8'h7C);
  assign bin_val   = (opcode == 8'h7C) ? (nxt_val + top_val) :
                     (opcode == 8'h6B) ? {32'd0, nxt_val[31:0] - top_val[31:0]} :
                                         {32'd0, nxt_val[31:0] + top_val[31:0]};
`else
  assign is_const  = (opcode == 8'h41);
  assign const_val = {32'd0, leb_raw[31:0]};
  assign is_bin    = (opcode == 8'h6A) || (opcode == 8'h6B);
  assign bin_val   = (opcode == 8'h6B) ? {32'd0, nxt_val[31:0] - top_val[31:0]} :
                                         {32'd0, nxt_val[31:0] + top_val[31:0]};
`endif
  assign unused_bits = ^{mem_data[127:8*(LEB_MAX+1)], leb_raw[RAW_W-1:RAW_USED]};

  // Next-state and architectural update; only EXEC without a trap touches pc, stack or depth.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    depth_d  = depth_q;
    trap_d   = trap_q;
    result_d = result_q;
    empty_d  = empty_q;
    wr_en    = 1'b0;
    wr_idx   = sp_q[SPW-1:0];
    wr_data  = 64'd0;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (mem_error) begin
          trap_d = TRAP_MEM;
        end else begin
          case (opcode)
            8'h00: trap_d = TRAP_UNREACH;
            8'h01: pc_d = pc_q + PCW'(1);
            8'h02: begin
              if (!blocktype_ok) begin
                trap_d = TRAP_ILLEGAL;
              end else if (depth_q == DW'(BLOCK_DEPTH)) begin
                trap_d = TRAP_BLOCK;
              end else begin
                depth_d = depth_q + DW'(1);
                pc_d    = pc_q + PCW'(2);
              end
            end
            8'h0B: begin
              if (depth_q != DW'(0)) begin
                depth_d = depth_q - DW'(1);
                pc_d    = pc_q + PCW'(1);
              end else begin
                trap_d = TRAP_END;
              end
            end
            8'h1A: begin
              if (sp_q == (SPW+1)'(0)) begin
                trap_d = TRAP_UNDER;
              end else begin
                sp_d     = sp_q - (SPW+1)'(1);
                pc_d     = pc_q + PCW'(1);
                empty_d  = (sp_q == (SPW+1)'(1));
                result_d = (sp_q == (SPW+1)'(1)) ? 64'd0 : nxt_val;
              end
            end
            default: begin
              if (is_const) begin
                if (!leb_done) begin
                  trap_d = TRAP_ILLEGAL;
                end else if (sp_q == (SPW+1)'(STACK_DEPTH)) begin
                  trap_d = TRAP_OVER;
                end else begin
                  wr_en    = 1'b1;
                  wr_idx   = sp_q[SPW-1:0];
                  wr_data  = const_val;
                  sp_d     = sp_q + (SPW+1)'(1);
                  pc_d     = pc_q + PCW'(leb_len) + PCW'(1);
                  result_d = const_val;
                  empty_d  = 1'b0;
                end
              end else if (is_bin) begin
                if (sp_q < (SPW+1)'(2)) begin
                  trap_d = TRAP_UNDER;
                end else begin
                  wr_en    = 1'b1;
                  wr_idx   = nxt_idx;
                  wr_data  = bin_val;
                  sp_d     = sp_q - (SPW+1)'(1);
                  pc_d     = pc_q + PCW'(1);
                  result_d = bin_val;
                  empty_d  = 1'b0;
                end
              end else begin
                trap_d = TRAP_ILLEGAL;
              end
            end
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (trap_d != TRAP_NONE) begin
      state_d = S_HALT;
    end else begin
      state_d = state_d;
    end
  end

  // State, pc, stack and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      sp_q     <= '0;
      depth_q  <= '0;
      trap_q   <= TRAP_NONE;
      result_q <= 64'd0;
      empty_q  <= 1'b1;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= 64'd0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      depth_q  <= depth_d;
      trap_q   <= trap_d;
      result_q <= result_d;
      empty_q  <= empty_d;
      if (wr_en) begin
        stack_q[wr_idx] <= wr_data;
      end
    end
  end

  assign result       = result_q;
  assign result_empty = empty_q;
  assign trap         = trap_q;
  assign mem_addr     = pc_q;
  assign mem_extra    = 4'd4;
endmodule

// File: tb/tb_wasm_core.sv
// Self-checking bench for wasm_core: directed programs plus random programs checked
// against a byte-level interpreter of the instruction set.
module tb_wasm_core;
`ifdef WASM_CORE_I64_EN
  localparam int LEB_MAX = 10;
`else
  localparam int LEB_MAX = 5;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  result;
  logic         result_empty;
  logic [3:0]   trap;
  logic [3:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data;
  logic         mem_error;

  logic [7:0]   rom [16];
  logic [7:0]   prog [$];
  int           ub = 15;
  int           checks = 0;
  int           errors = 0;

  wasm_core dut (
    .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
    .trap(trap), .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  // ROM: 16-byte window wrapping modulo the address space; addresses past ub flag mem_error.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      mem_data[8*k +: 8] = rom[4'(mem_addr + 4'(k))];
    end
    mem_error = (int'(mem_addr) > ub);
  end

  task automatic set_rom(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) begin
      rom[i] = (i < prog.size()) ? prog[i] : fill;
    end
  endtask

  task automatic run_dut(input int max_cycles);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (trap !== 4'd0) break;
    end
  endtask

  // Reference interpreter over the ROM image.
  task automatic model_run(output int m_trap, output longint unsigned m_res, output bit m_empty);
    longint unsigned st [$];
    longint unsigned v, a, b2;
    int pc, depth, shift, n;
    bit done;
    logic [7:0] op, b;
    pc = 0; depth = 0; m_trap = 0; st = {};
    for (int step = 0; step < 1000 && m_trap == 0; step++) begin
      if (pc > ub) begin
        m_trap = 6;
        break;
      end
      op = rom[pc];
      case (op)
        8'h00: m_trap = 2;
        8'h01: pc = (pc + 1) % 16;
        8'h02: begin
          b = rom[(pc + 1) % 16];
          if (b != 8'h40 && b != 8'h7F && b != 8'h7E) m_trap = 3;
          else if (depth == 8) m_trap = 7;
          else begin depth++; pc = (pc + 2) % 16; end
        end
        8'h0B: begin
          if (depth > 0) begin depth--; pc = (pc + 1) % 16; end
          else m_trap = 1;
        end
        8'h1A: begin
          if (st.size() == 0) m_trap = 5;
          else begin void'(st.pop_back()); pc = (pc + 1) % 16; end
        end
`ifdef WASM_CORE_I64_EN
        8'h41, 8'h42: begin
`else
        8'h41: begin
`endif
          v = 0; shift = 0; n = 0; done = 0; b = 8'h00;
          while (!done && n < LEB_MAX) begin
            b = rom[(pc + 1 + n) % 16];
            if (shift < 64) v = v | ({56'd0, b & 8'h7F} << shift);
            shift += 7;
            n++;
            if (b[7] == 1'b0) done = 1;
          end
          if (!done) m_trap = 3;
          else begin
            if (b[6] && shift < 64) v = v | (~64'd0 << shift);
            if (op == 8'h41) v = v & 64'hFFFF_FFFF;
            if (st.size() == 16) m_trap = 4;
            else begin st.push_back(v); pc = (pc + 1 + n) % 16; end
          end
        end
`ifdef WASM_CORE_I64_EN
        8'h6A, 8'h6B, 8'h7C: begin
`else
        8'h6A, 8'h6B: begin
`endif
          if (st.size() < 2) m_trap = 5;
          else begin
            b2 = st.pop_back();
            a = st.pop_back();
            if (op == 8'h6A) st.push_back((a + b2) & 64'hFFFF_FFFF);
            else if (op == 8'h6B) st.push_back((a - b2) & 64'hFFFF_FFFF);
            else st.push_back(a + b2);
            pc = (pc + 1) % 16;
          end
        end
        default: m_trap = 3;
      endcase
    end
    m_empty = (st.size() == 0);
    m_res = m_empty ? 64'd0 : st[$];
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 64'd0 || result_empty !== 1'b1 || trap !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: result=%0h empty=%0b trap=%0d, want 0/1/0", result, result_empty, trap);
    end
    checks++;
    if (mem_addr !== 4'd0 || mem_extra !== 4'd4) begin
      errors++;
      $display("FAIL reset_mem: addr=%0d extra=%0d, want 0/4", mem_addr, mem_extra);
    end
  endtask

  task automatic test_block;
    prog = {8'h02, 8'h40, 8'h41, 8'h2A, 8'h0B, 8'h0B};
    set_rom(8'h00);
    ub = 15;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (result !== 64'd42 || result_empty !== 1'b0 || trap !== 4'd1) begin
      errors++;
      $display("FAIL block: result=%0d empty=%0b trap=%0d, want 42/0/1", result, result_empty, trap);
    end
  endtask

  task automatic test_arith;
    prog = {8'h41, 8'h05, 8'h41, 8'h03, 8'h6B, 8'h0B};
    set_rom(8'h00);
    run_dut(100);
    checks++;
    if (result !== 64'd2 || trap !== 4'd1) begin
      errors++;
      $display("FAIL sub: result=%0h trap=%0d, want 2/1", result, trap);
    end
    prog = {8'h41, 8'h7F, 8'h41, 8'h01, 8'h6A, 8'h0B};
    set_rom(8'h00);
    run_dut(100);
    checks++;
    if (result !== 64'd0 || result_empty !== 1'b0 || trap !== 4'd1) begin
      errors++;
      $display("FAIL add_wrap: result=%0h empty=%0b trap=%0d, want 0/0/1", result, result_empty, trap);
    end
  endtask

  task automatic test_traps;
    prog = {8'h00};
    set_rom(8'h00);
    run_dut(100);
    checks++;
    if (trap !== 4'd2 || result_empty !== 1'b1) begin
      errors++;
      $display("FAIL unreachable: trap=%0d empty=%0b, want 2/1", trap, result_empty);
    end
    prog = {8'h1A};
    set_rom(8'h00);
    run_dut(100);
    checks++;
    if (trap !== 4'd5) begin
      errors++;
      $display("FAIL drop_empty: trap=%0d, want 5", trap);
    end
    prog = {8'hFE};
    set_rom(8'h00);
    run_dut(100);
    checks++;
    if (trap !== 4'd3) begin
      errors++;
      $display("FAIL illegal: trap=%0d, want 3", trap);
    end
    prog = {};
    set_rom(8'h01);
    ub = 3;
    run_dut(100);
    checks++;
    if (trap !== 4'd6 || mem_addr !== 4'd4) begin
      errors++;
      $display("FAIL mem_error: trap=%0d addr=%0d, want 6/4", trap, mem_addr);
    end
    ub = 15;
  endtask

  task automatic test_overflow;
    prog = {};
    for (int i = 0; i < 8; i++) begin
      prog.push_back(8'h41);
      prog.push_back(8'h01);
    end
    set_rom(8'h00);
    run_dut(200);
    checks++;
    if (trap !== 4'd4 || result !== 64'd1) begin
      errors++;
      $display("FAIL stack_overflow: trap=%0d result=%0h, want 4/1", trap, result);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (trap !== 4'd4 || result !== 64'd1 || mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL halt_hold: trap=%0d result=%0h addr=%0d, want 4/1/0", trap, result, mem_addr);
    end
    prog = {};
    for (int i = 0; i < 8; i++) begin
      prog.push_back(8'h02);
      prog.push_back(8'h40);
    end
    set_rom(8'h00);
    run_dut(200);
    checks++;
    if (trap !== 4'd7) begin
      errors++;
      $display("FAIL block_overflow: trap=%0d, want 7", trap);
    end
  endtask

  task automatic test_reset_midrun;
    prog = {8'h41, 8'h05, 8'h41, 8'h03, 8'h6B, 8'h0B};
    set_rom(8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (result !== 64'd5 || result_empty !== 1'b0) begin
      errors++;
      $display("FAIL midrun_pre: result=%0h empty=%0b, want 5/0", result, result_empty);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (result !== 64'd0 || result_empty !== 1'b1 || trap !== 4'd0 || mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: result=%0h empty=%0b trap=%0d addr=%0d, want 0/1/0/0",
               result, result_empty, trap, mem_addr);
    end
    run_dut(100);
    checks++;
    if (result !== 64'd2 || trap !== 4'd1) begin
      errors++;
      $display("FAIL midrun_rerun: result=%0h trap=%0d, want 2/1", result, trap);
    end
  endtask

  task automatic test_i64;
    prog = {8'h42, 8'h7F, 8'h42, 8'h02, 8'h7C, 8'h0B};
    set_rom(8'h00);
    run_dut(100);
    checks++;
`ifdef WASM_CORE_I64_EN
    if (result !== 64'd1 || trap !== 4'd1) begin
      errors++;
      $display("FAIL i64_add: result=%0h trap=%0d, want 1/1", result, trap);
    end
`else
    if (trap !== 4'd3 || result_empty !== 1'b1) begin
      errors++;
      $display("FAIL i64_disabled: trap=%0d empty=%0b, want 3/1", trap, result_empty);
    end
`endif
  endtask

  task automatic test_random;
    int v, m_trap;
    longint unsigned m_res;
    bit m_empty, more;
    logic [7:0] b;
    for (int it = 0; it < 60; it++) begin
      prog = {};
      while (prog.size() < 10) begin
        case ($urandom_range(0, 9))
          0: prog.push_back(8'h01);
          1, 2, 3: begin
            v = $signed($urandom) >>> $urandom_range(0, 31);
            prog.push_back(($urandom_range(0, 5) == 0) ? 8'h42 : 8'h41);
            more = 1'b1;
            while (more) begin
              b = 8'(v & 32'h7F);
              v = v >>> 7;
              more = !((v == 0 && !b[6]) || (v == -1 && b[6]));
              if (more) b[7] = 1'b1;
              prog.push_back(b);
            end
          end
          4: prog.push_back(8'h6A);
          5: prog.push_back(8'h6B);
          6: prog.push_back(8'h1A);
          7: begin
            prog.push_back(8'h02);
            prog.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h7F);
          end
          8: prog.push_back(8'h0B);
          default: prog.push_back(($urandom_range(0, 1) == 0) ? 8'h7C : 8'($urandom));
        endcase
      end
      prog.push_back(8'h0B);
      while (prog.size() > 14) void'(prog.pop_back());
      set_rom(8'h00);
      ub = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 15) : 15;
      model_run(m_trap, m_res, m_empty);
      run_dut(400);
      checks++;
      if (trap !== 4'(m_trap) || result !== m_res || result_empty !== m_empty) begin
        errors++;
        $display("FAIL random[%0d]: trap=%0d result=%0h empty=%0b, want %0d/%0h/%0b",
                 it, trap, result, result_empty, m_trap, m_res, m_empty);
      end
    end
    ub = 15;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    test_reset;
    test_block;
    test_arith;
    test_traps;
    test_overflow;
    test_reset_midrun;
    test_i64;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wasm_core.md
Name: wasm_core

Overview:
- Minimal WebAssembly stack-machine core executing a byte-coded instruction subset fetched from a ROM-style memory port.
- Fetches a 16-byte window per instruction, decodes the opcode plus LEB128 immediates, maintains an operand stack and a block-nesting counter.
- Exposes top-of-stack as `result` and halts with a trap code.
- Sits between the program ROM (genrom, 1-cycle registered read) and the system wrapper.

Parameters:
- MEM_DEPTH, 3: memory address MSB index; mem_addr is MEM_DEPTH+1 bits wide.
- STACK_DEPTH, 16: operand stack entries, 64 bits each; power of 2.
- BLOCK_DEPTH, 8: maximum block nesting levels.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- result  out  64  top-of-stack value; 0 when stack empty.
- result_empty  out  1  1 when operand stack is empty.
- trap  out  4  0=running, 1=ended normally, 2=unreachable, 3=illegal opcode, 4=stack overflow, 5=stack underflow, 6=memory error, 7=block overflow.
- mem_addr  out  MEM_DEPTH+1  byte address of fetch window (= pc).
- mem_extra  out  4  log2 of window size requested; always 4'd4 (16 bytes).
- mem_data  in  128  fetched window; byte k at bits [8k+7:8k], byte 0 = byte at mem_addr.
- mem_error  in  1  fetch out of ROM bounds; valid with mem_data.

Behaviour:
- Reset (async, reset==0): pc=0, stack pointer=0, block depth=0, state=FETCH, trap=0, result=0, result_empty=1. Reset asserted mid-execution aborts immediately.
- FETCH (1 cycle): drive mem_addr=pc, mem_extra=4; go to EXEC. mem_addr holds pc in all states.
- EXEC (1 cycle): mem_data valid. If mem_error, set trap=6 and go to HALT. Otherwise decode byte 0:
  - 0x00 unreachable -> trap=2.
  - 0x01 nop -> pc+=1.
  - 0x02 block: byte 1 blocktype; accept only 0x40, 0x7F, 0x7E, else trap=3. Block depth +1 (at BLOCK_DEPTH -> trap=7); pc+=2.
  - 0x0B end: block depth>0 -> depth-1, pc+=1; depth==0 -> trap=1 (function end).
  - 0x1A drop: pop; empty -> trap=5.
  - 0x41 i32.const: signed LEB128, 1-5 bytes, continuation bit 7. Value truncated to 32 bits, zero-extended to 64. Push; pc+=1+len.
  - 0x6A i32.add / 0x6B i32.sub: pop b, pop a, push (a op b) mod 2^32, zero-extended. <2 entries -> trap=5.
  - Any other opcode -> trap=3.
- Push with STACK_DEPTH entries -> trap=4; stack unchanged.
- Any nonzero trap moves to HALT. HALT is absorbing until reset; no further stack or pc changes.
- Throughput: 2 cycles per instruction. Architectural updates happen on the EXEC clock edge.
- result/result_empty are registered, reflect stack state after each EXEC, and remain valid in HALT.
- pc wraps modulo 2^(MEM_DEPTH+1). Bounds violations arrive via mem_error.
- Block result types are not checked; values stay on the stack at end. No branch instructions.

Optional Feature:
- Macro WASM_CORE_I64_EN.
- Defined: adds 0x42 i64.const (signed LEB128, 1-10 bytes, sign-extended to 64 bits) and 0x7C i64.add (64-bit wrap).
- Undefined: 0x42 and 0x7C decode as illegal (trap=3); LEB128 decoder limited to 5 bytes.

Test Plan:
- Block program: ROM 02 40 41 2A 0B 0B; release reset; after 12 cycles -> result=42, result_empty=0, trap=1.
- Arithmetic: 41 05 41 03 6B 0B -> result=2; bytes 41 7F 41 01 6A 0B -> result=0 (0xFFFFFFFF+1 wraps), trap=1.
- Traps: 00 -> trap=2, result_empty=1; 1A -> trap=5; FE -> trap=3; pc walking past upper_bound (mem_error) -> trap=6.
- Overflow: 17 consecutive 41 01 with STACK_DEPTH=16 -> trap=4, result=1. Nine nested 02 40 -> trap=7.
- Reset mid-run: assert reset during EXEC of second instruction -> outputs immediately 0/1/0; rerun after release gives same result as first run.
- With WASM_CORE_I64_EN: 42 7F 42 02 7C 0B -> result=1 (-1+2); without it -> trap=3.
